// File: rtl/cp0_unit_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes,
// and the handler entry address.
package cp0_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned HWINT_W   = 6;
  localparam int unsigned EXCCODE_W = 5;

  // CP0 register numbers
  localparam logic [REG_AW-1:0] CP0_SR    = 5'd12;
  localparam logic [REG_AW-1:0] CP0_CAUSE = 5'd13;
  localparam logic [REG_AW-1:0] CP0_EPC   = 5'd14;
  localparam logic [REG_AW-1:0] CP0_PRID  = 5'd15;

  // SR / Cause field positions
  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  // Exception codes
  localparam logic [EXCCODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXCCODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXCCODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXCCODE_W-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] EXC_ENTRY_ADDR = 32'h0000_4180;
  localparam logic [XLEN-1:0] PRID_VALUE     = 32'h2022_1217;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception request, mfc0/mtc0/eret.
// Ports:
//   clk, reset (async active-low)
//   valid_M, PC_M, isBD_M, isExc_M, excCode_M : M-stage instruction info
//   HWInt                                     : external interrupt lines
//   rd_addr / rd_data                         : mfc0 read (combinational)
//   wr_en, wr_addr, wr_data                   : mtc0 write
//   eret_M                                    : eret in M
//   Req                                       : flush + redirect this cycle (combinational)
//   handler_pc                                : exception entry address
//   EPC_out                                   : eret return address
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID      = PRID_VALUE,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic [31:0] PC_M,
  input  logic        isBD_M,
  input  logic        isExc_M,
  input  logic [4:0]  excCode_M,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        eret_M,
  output logic [31:0] rd_data,
  output logic        Req,
  output logic [31:0] handler_pc,
  output logic [31:0] EPC_out
);

  logic [HWINT_W-1:0]   sr_im_q,     sr_im_d;
  logic                 sr_exl_q,    sr_exl_d;
  logic                 sr_ie_q,     sr_ie_d;
  logic                 cause_bd_q,  cause_bd_d;
  logic [HWINT_W-1:0]   cause_ip_q,  cause_ip_d;
  logic [EXCCODE_W-1:0] cause_exc_q, cause_exc_d;
  logic [XLEN-1:0]      epc_q,       epc_d;

  logic int_req;
  logic exc_req;
  logic [XLEN-1:0] sr_val;
  logic [XLEN-1:0] cause_val;

  // Request: interrupt wins over exception; reset drops any pending request
  always_comb begin
    int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q & valid_M;
    exc_req = isExc_M & ~sr_exl_q & valid_M;
    Req     = (int_req | exc_req) & reset;
  end

  // Next state: Req > eret > mtc0; Cause.IP samples HWInt every edge
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (Req) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? EXC_INT : excCode_M;
      cause_bd_d  = isBD_M;
      epc_d       = isBD_M ? (PC_M - 32'd4) : PC_M;
    end else if (eret_M) begin
      sr_exl_d = 1'b0;
    end else if (wr_en) begin
      if (wr_addr == CP0_SR) begin
        sr_im_d  = wr_data[SR_IM_LSB +: HWINT_W];
        sr_exl_d = wr_data[SR_EXL_BIT];
        sr_ie_d  = wr_data[SR_IE_BIT];
      end else if (wr_addr == CP0_EPC) begin
        epc_d = wr_data;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // Read mux (no forwarding of in-flight mtc0 data)
  always_comb begin
    sr_val    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    cause_val = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
    case (rd_addr)
      CP0_SR:    rd_data = sr_val;
      CP0_CAUSE: rd_data = cause_val;
      CP0_EPC:   rd_data = epc_q;
      CP0_PRID:  rd_data = PRID;
      default:   rd_data = '0;
    endcase
  end

  // EPC_out forwards an mtc0 EPC so a back-to-back eret sees the new value
  always_comb begin
    EPC_out    = (wr_en && (wr_addr == CP0_EPC)) ? wr_data : epc_q;
    handler_pc = EXC_ENTRY;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline. Sits directly downstream of the M-stage exception detector.
- Consumes the detector's exception flag and code, plus the M-stage PC, branch-delay flag and the 6 external hardware interrupt lines.
- Holds SR, Cause, EPC and PRId; raises the pipeline flush/redirect request; serves mfc0/mtc0/eret.
- All architectural CP0 state updates on the clock edge; the request output is combinational so the pipeline can flush in the same cycle.

Parameters:
PRID, 32'h2022_1217, value returned for register 15
EXC_ENTRY, 32'h0000_4180, handler address driven on handler_pc

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_M  in  1  M stage holds a real instruction (0 = bubble)
PC_M  in  32  PC of the M-stage instruction
isBD_M  in  1  M-stage instruction sits in a branch delay slot
isExc_M  in  1  exception flag from the M-stage detector
excCode_M  in  5  exception code from the M-stage detector
HWInt  in  6  external interrupt lines (timer0, timer1, device …)
rd_addr  in  5  mfc0 register number
wr_addr  in  5  mtc0 register number
wr_en  in  1  mtc0 in M, already qualified by valid_M
wr_data  in  32  mtc0 data
eret_M  in  1  eret in M
rd_data  out  32  mfc0 read data (combinational)
Req  out  1  take interrupt/exception this cycle (flush F–M, redirect PC)
handler_pc  out  32  constant EXC_ENTRY
EPC_out  out  32  eret return address

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]. Other bits read 0 and are not writable.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0. Not writable by mtc0.
  - EPC(14): 32 bits, read/write.
  - PRId(15): constant PRID.
  - Any other address reads 0; writes to it are ignored.
- Reset (reset=0, asynchronous):
  - SR=0, Cause=0, EPC=0.
  - Consequently Req=0 and EPC_out=0.
- Request logic (combinational):
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL & valid_M.
  - ExcReq = isExc_M & ~SR.EXL & valid_M.
  - Req = IntReq | ExcReq.
  - Interrupt has priority over exception when both are present.
- Every rising edge: Cause.IP <= HWInt, regardless of any other event (level-sampled, no latching).
- On Req (same edge):
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : excCode_M.
  - Cause.BD <= isBD_M.
  - EPC <= isBD_M ? PC_M-4 : PC_M. The low 2 bits are kept, so a misaligned-fetch PC is preserved.
- eret_M without Req: EXL <= 0.
- mtc0 without Req:
  - SR and EPC are written.
  - Req suppresses mtc0 in the same cycle (the instruction is flushed).
- Write priority on one edge: Req > eret_M > mtc0. eret and mtc0 together cannot occur (same stage).
- Read path:
  - rd_data is the register's current value; there is no same-cycle forwarding of wr_data.
  - Exception: EPC_out forwards wr_data when wr_en & wr_addr==14, so an mtc0 EPC followed by eret works.
- Latency:
  - Req goes high in the same cycle its inputs are valid.
  - State is visible on rd_data the cycle after the edge.
- Nested events:
  - While EXL=1 no Req is raised, even with isExc_M=1.
  - Interrupts stay masked until eret clears EXL.
- Reset mid-operation: returns to the reset state immediately; a pending Req is dropped.

Decomposition:
- Shared constants file gains:
  - CP0 register numbers (12–15).
  - SR/Cause bit-field positions.
  - Exception codes (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
  - EXC_ENTRY.
- Single module. The request/priority logic stays inline, so no sub-module is needed.

Test Plan:
1. Reset low mid-run with EPC nonzero → SR=0, Cause=0, EPC=0, Req=0, asynchronously, before the next edge.
2. mtc0 SR=32'h0000_0401 (IM bit10, IE), then HWInt=6'b000001, valid_M=1, PC_M=32'h3010 → Req=1 that cycle; next cycle EXL=1, Cause ExcCode=0, IP=1, EPC=32'h3010.
3. isExc_M=1, excCode_M=4, isBD_M=1, PC_M=32'h3024 → Req=1; EPC=32'h3020, Cause=32'h8000_0010.
4. Same exception with EXL already 1, or with valid_M=0 → Req=0; EPC and Cause unchanged.
5. Interrupt and exception in the same cycle (code 12) → ExcCode=0; then eret_M → EXL=0 next cycle, EPC_out equals the saved PC.
6. mtc0 EPC=32'h3100 with wr_en and Req simultaneously high → EPC takes the exception PC, not 32'h3100; the next-cycle mtc0 EPC=32'h3100 shows on EPC_out the same cycle via forwarding.
